uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16: clk cycles per bit, even, legal range 8..64.
REQ-003 Parameter STOP_BITS, default 1: stop bits checked per frame, legal values 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0: 1 selects odd parity, 0 selects even; used only when UART_RX_PARITY_EN is defined.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 rx  input  1  asynchronous serial line; idles high.
REQ-008 data  output  DATA_BITS  last received word, LSB received first.
REQ-009 valid  output  1  one-cycle pulse; data holds a good frame.
REQ-010 frame_err  output  1  one-cycle pulse; a stop bit was sampled low.
REQ-011 parity_err  output  1  one-cycle pulse; parity mismatch (tied 0 without macro).
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use; synchronized value is rx_s.
REQ-014 Each bit value SHALL be the majority of rx_s at sample_cnt M-1, M, M+1 (M = OVERSAMPLE/2), decided at count M+1.
REQ-015 States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK_WAIT; encodings live in the package.
REQ-016 IDLE -> START when rx_s is 0; sample_cnt is cleared to 0 on that same edge.
REQ-017 START: if the start-bit majority is 1, return to IDLE with no output pulse (glitch rejection).
REQ-018 sample_cnt SHALL count 0..OVERSAMPLE-1 and wrap; each wrap marks a bit boundary.
REQ-019 DATA: shift in DATA_BITS bits LSB first, then go to PARITY if compiled in, else to STOP.
REQ-020 STOP: check STOP_BITS bits; any low stop bit sets the frame error.
REQ-021 At the decision point of the final stop bit, register results; outputs assert on the next cycle and the FSM enters IDLE that same cycle, with no dead state, so a start edge in the following half bit is accepted.
REQ-022 Good frame: data updated and valid=1 for one cycle.
REQ-023 Any error: data updated, valid stays 0, and the relevant error pulses; frame_err and parity_err may pulse together.
REQ-024 After a frame error, enter BREAK_WAIT instead of IDLE; remain there until rx_s=1, then go to IDLE.
REQ-025 data SHALL hold its value between frames; valid, frame_err and parity_err are never high for more than one cycle.

Reset
REQ-026 On rst_n low, immediately: state=IDLE, sample_cnt=0, bit_cnt=0, shift register=0, data=0, valid=0, frame_err=0, parity_err=0, busy=0, synchronizer flops=1.
REQ-027 Reset mid-frame discards the partial frame; no output pulse follows the reset release.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state is present and the received parity bit is checked against PARITY_ODD.
REQ-029 Macro UART_RX_PARITY_EN undefined: no parity bit in the frame, PARITY state absent, parity_err tied to 0.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum, a default OVERSAMPLE constant, and a parity-function helper.
REQ-031 Sub-module uart_rx_sampler SHALL contain the synchronizer and the 3-sample majority voter; all counters and the FSM stay in uart_rx_cfg.

Verification (defaults unless stated)
REQ-032 Frame 0x55 with 1 stop bit -> single valid pulse, data=0x55, busy low after the pulse, both error outputs 0.
REQ-033 rx low for 4 cycles then high -> busy rises, then returns to IDLE; no valid, no error pulse.
REQ-034 Frame 0xA3 with stop bit held low, rx low for 3 further bit times -> frame_err pulse, no valid; next start edge is ignored until rx goes high.
REQ-035 Macro defined, PARITY_ODD=1, frame 0x0F with parity bit 0 -> parity_err pulse, no valid, data=0x0F.
REQ-036 Frames 0x12 and 0x34 sent back to back with no idle gap -> two valid pulses exactly 10*16 cycles apart, data 0x12 then 0x34.
REQ-037 DATA_BITS=7, STOP_BITS=2, rst_n pulsed low during bit 3 of a frame -> all outputs 0; the next clean frame 0x41 -> valid, data=0x41.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_rx_cfg receiver.
// The PARITY state encoding exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DefaultOversample = 16;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StStart     = 3'd1,
        StData      = 3'd2,
        StStop      = 3'd3,
        StBreakWait = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        StParity    = 3'd5
`endif
    } uart_state_e;

    // Expected parity bit for the low nbits of word: even parity when odd=0.
    function automatic logic parity_bit(input logic [8:0] word, input int nbits, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 9; i++) begin
            if (i < nbits) begin
                p = p ^ word[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer and 3-sample majority voter for uart_rx_cfg.
// bit_val is meaningful in the cycle where sample_cnt equals OVERSAMPLE/2 + 1.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic [CNT_W-1:0] sample_cnt,
    output logic             rx_s,
    output logic             bit_val
);

    localparam int MID = OVERSAMPLE / 2;
    localparam logic [CNT_W-1:0] CntEarly = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CntMid   = CNT_W'(MID);

    logic sync_1;
    logic sync_2;
    logic samp_early;
    logic samp_mid;

    // Flops reset to 1 so a released reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            samp_early <= 1'b1;
            samp_mid   <= 1'b1;
        end else begin
            sync_1 <= rx;
            sync_2 <= sync_1;
            if (sample_cnt == CntEarly) begin
                samp_early <= sync_2;
            end
            if (sample_cnt == CntMid) begin
                samp_mid <= sync_2;
            end
        end
    end

    assign rx_s    = sync_2;
    assign bit_val = (samp_early & samp_mid) | (samp_early & sync_2) | (samp_mid & sync_2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with glitch rejection and break handling.
// Define UART_RX_PARITY_EN to add a checked parity bit after the data bits.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = DefaultOversample,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CntDecide = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       LastData  = 4'(DATA_BITS);
    localparam logic [3:0]       LastStop  = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE > 64 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_cfg: OVERSAMPLE must be even and 8..64");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_misc
        $error("uart_rx_cfg: STOP_BITS must be 1..2 and PARITY_ODD 0..1");
    end

    uart_state_e          state;
    logic [CNT_W-1:0]     sample_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_err;
    logic                 rx_s;
    logic                 bit_val;
    logic                 decide;
    logic                 wrap;
    logic                 stop_bad;
    logic                 par_bad;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE),
        .CNT_W     (CNT_W)
    ) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .sample_cnt(sample_cnt),
        .rx_s      (rx_s),
        .bit_val   (bit_val)
    );

    assign decide   = (sample_cnt == CntDecide);
    assign wrap     = (sample_cnt == CntLast);
    assign stop_bad = stop_err | ~bit_val;

`ifdef UART_RX_PARITY_EN
    logic par_err;
    logic parity_pulse;
    assign par_bad    = par_err;
    assign parity_err = parity_pulse;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            sample_cnt   <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            stop_err     <= 1'b0;
            data         <= '0;
            valid        <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err      <= 1'b0;
            parity_pulse <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_pulse <= 1'b0;
`endif
            if (state == StIdle || state == StBreakWait || wrap) begin
                sample_cnt <= '0;
            end else begin
                sample_cnt <= sample_cnt + 1'b1;
            end

            case (state)
                StIdle: begin
                    if (!rx_s) begin
                        state <= StStart;
                        busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (decide && bit_val) begin
                        state      <= StIdle;
                        busy       <= 1'b0;
                        sample_cnt <= '0;
                    end else if (wrap) begin
                        state   <= StData;
                        bit_cnt <= '0;
                    end
                end
                StData: begin
                    if (decide) begin
                        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    if (wrap && bit_cnt == LastData) begin
                        bit_cnt  <= '0;
                        stop_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        state    <= StParity;
`else
                        state    <= StStop;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (decide) begin
                        par_err <= (bit_val != parity_bit(9'(shreg), DATA_BITS, 1'(PARITY_ODD)));
                    end
                    if (wrap) begin
                        state <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (decide) begin
                        if (bit_cnt == LastStop) begin
                            // Results and the return to IDLE land on the same edge.
                            data       <= shreg;
                            valid      <= ~(stop_bad | par_bad);
                            frame_err  <= stop_bad;
`ifdef UART_RX_PARITY_EN
                            parity_pulse <= par_err;
`endif
                            state      <= stop_bad ? StBreakWait : StIdle;
                            busy       <= stop_bad;
                            sample_cnt <= '0;
                            bit_cnt    <= '0;
                            stop_err   <= 1'b0;
                        end else begin
                            stop_err <= stop_bad;
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end
                end
                StBreakWait: begin
                    if (rx_s) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: default-config DUT plus a 7-bit, 2-stop-bit DUT.
// Honours UART_RX_PARITY_EN by appending parity bits to every sent frame.
module tb_uart_rx_cfg;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit ParEn   = 1'b1;
    localparam int FrameA  = 11 * OS;
`else
    localparam bit ParEn   = 1'b0;
    localparam int FrameA  = 10 * OS;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a;
    logic       valid_a, ferr_a, perr_a, busy_a;
    logic [6:0] data_b;
    logic       valid_b, ferr_b, perr_b, busy_b;

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .DATA_BITS (8),
        .OVERSAMPLE(OS),
        .STOP_BITS (1),
        .PARITY_ODD(1)
    ) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx_a),
        .data      (data_a),
        .valid     (valid_a),
        .frame_err (ferr_a),
        .parity_err(perr_a),
        .busy      (busy_a)
    );

    uart_rx_cfg #(
        .DATA_BITS (7),
        .OVERSAMPLE(OS),
        .STOP_BITS (2),
        .PARITY_ODD(0)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx_b),
        .data      (data_b),
        .valid     (valid_b),
        .frame_err (ferr_b),
        .parity_err(perr_b),
        .busy      (busy_b)
    );

    // Pulse monitor, sampled on the falling edge.
    int         cyc = 0;
    int         n_valid_a = 0, n_ferr_a = 0, n_perr_a = 0;
    int         n_valid_b = 0, n_ferr_b = 0, n_perr_b = 0;
    int         n_wide = 0;
    int         vcyc_last = 0, vcyc_prev = 0;
    logic [7:0] vdat_last = '0, vdat_prev = '0;
    logic       pv_a = 0, pf_a = 0, pp_a = 0, pv_b = 0, pf_b = 0, pp_b = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (valid_a) begin
            n_valid_a <= n_valid_a + 1;
            vcyc_prev <= vcyc_last;
            vcyc_last <= cyc;
            vdat_prev <= vdat_last;
            vdat_last <= data_a;
        end
        if (ferr_a) n_ferr_a <= n_ferr_a + 1;
        if (perr_a) n_perr_a <= n_perr_a + 1;
        if (valid_b) n_valid_b <= n_valid_b + 1;
        if (ferr_b) n_ferr_b <= n_ferr_b + 1;
        if (perr_b) n_perr_b <= n_perr_b + 1;
        if ((valid_a && pv_a) || (ferr_a && pf_a) || (perr_a && pp_a) ||
            (valid_b && pv_b) || (ferr_b && pf_b) || (perr_b && pp_b)) begin
            n_wide <= n_wide + 1;
        end
        pv_a <= valid_a; pf_a <= ferr_a; pp_a <= perr_a;
        pv_b <= valid_b; pf_b <= ferr_b; pp_b <= perr_b;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input bit line_b, input logic v);
        if (line_b) rx_b = v;
        else        rx_a = v;
    endtask

    task automatic send(input bit line_b, input logic [8:0] d, input int nbits, input int nstop,
                        input logic stop_lvl, input logic par_odd, input logic par_flip);
        logic p;
        p = par_odd ^ par_flip;
        set_rx(line_b, 1'b0);
        tick(OS);
        for (int i = 0; i < nbits; i++) begin
            set_rx(line_b, d[i]);
            p = p ^ d[i];
            tick(OS);
        end
        if (ParEn) begin
            set_rx(line_b, p);
            tick(OS);
        end
        for (int i = 0; i < nstop; i++) begin
            set_rx(line_b, stop_lvl);
            tick(OS);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop_lvl;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];
    int   v0, f0, p0, vb0, fb0;
    logic seen;

    initial begin
        vecs[0] = '{d: 8'h55, stop_lvl: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[1] = '{d: 8'h00, stop_lvl: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[2] = '{d: 8'hFF, stop_lvl: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[3] = '{d: 8'hA3, stop_lvl: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[4] = '{d: 8'h80, stop_lvl: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
        vecs[5] = '{d: 8'h3C, stop_lvl: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};
        vecs[6] = '{d: 8'h01, stop_lvl: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};

        rst_n = 1'b0;
        tick(3);
        check("rst_data_a", 32'(data_a), 32'h0);
        check("rst_valid_a", 32'(valid_a), 32'h0);
        check("rst_ferr_a", 32'(ferr_a), 32'h0);
        check("rst_perr_a", 32'(perr_a), 32'h0);
        check("rst_busy_a", 32'(busy_a), 32'h0);
        rst_n = 1'b1;
        tick(4);

        for (int i = 0; i < 7; i++) begin
            v0 = n_valid_a;
            f0 = n_ferr_a;
            send(1'b0, {1'b0, vecs[i].d}, 8, 1, vecs[i].stop_lvl, 1'b1, 1'b0);
            rx_a = 1'b1;
            tick(2 * OS);
            check($sformatf("vec%0d_valid", i), 32'(n_valid_a - v0), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ferr", i), 32'(n_ferr_a - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_data", i), 32'(data_a), 32'(vecs[i].d));
            check($sformatf("vec%0d_busy", i), 32'(busy_a), 32'h0);
        end

        // Short low glitch: busy rises, then the start bit is rejected.
        v0 = n_valid_a;
        f0 = n_ferr_a;
        rx_a = 1'b0;
        tick(4);
        rx_a = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (busy_a) seen = 1'b1;
        end
        check("glitch_busy_rose", 32'(seen), 32'h1);
        tick(40);
        check("glitch_busy_low", 32'(busy_a), 32'h0);
        check("glitch_no_valid", 32'(n_valid_a - v0), 32'h0);
        check("glitch_no_ferr", 32'(n_ferr_a - f0), 32'h0);
        check("glitch_data_kept", 32'(data_a), 32'h01);

        // Break: stop bit low and line held low for three more bit times.
        v0 = n_valid_a;
        f0 = n_ferr_a;
        send(1'b0, 9'h0A3, 8, 1, 1'b0, 1'b1, 1'b0);
        tick(3 * OS);
        check("break_ferr", 32'(n_ferr_a - f0), 32'h1);
        check("break_no_valid", 32'(n_valid_a - v0), 32'h0);
        check("break_data", 32'(data_a), 32'hA3);
        check("break_busy_held", 32'(busy_a), 32'h1);
        rx_a = 1'b1;
        tick(6);
        check("break_busy_released", 32'(busy_a), 32'h0);
        check("break_single_ferr", 32'(n_ferr_a - f0), 32'h1);

        // Back-to-back frames with no idle gap.
        v0 = n_valid_a;
        send(1'b0, 9'h012, 8, 1, 1'b1, 1'b1, 1'b0);
        send(1'b0, 9'h034, 8, 1, 1'b1, 1'b1, 1'b0);
        rx_a = 1'b1;
        tick(2 * OS);
        check("b2b_valid_count", 32'(n_valid_a - v0), 32'h2);
        check("b2b_spacing", 32'(vcyc_last - vcyc_prev), 32'(FrameA));
        check("b2b_first_data", 32'(vdat_prev), 32'h12);
        check("b2b_second_data", 32'(vdat_last), 32'h34);

`ifdef UART_RX_PARITY_EN
        // Odd parity: 0x0F needs parity 1; send 0.
        v0 = n_valid_a;
        f0 = n_ferr_a;
        p0 = n_perr_a;
        send(1'b0, 9'h00F, 8, 1, 1'b1, 1'b1, 1'b1);
        rx_a = 1'b1;
        tick(2 * OS);
        check("par_perr", 32'(n_perr_a - p0), 32'h1);
        check("par_no_valid", 32'(n_valid_a - v0), 32'h0);
        check("par_no_ferr", 32'(n_ferr_a - f0), 32'h0);
        check("par_data", 32'(data_a), 32'h0F);
`else
        check("noparity_perr_a", 32'(n_perr_a), 32'h0);
`endif

        // 7-bit / 2-stop instance: good frame, then reset mid-frame.
        vb0 = n_valid_b;
        send(1'b1, 9'h02A, 7, 2, 1'b1, 1'b0, 1'b0);
        rx_b = 1'b1;
        tick(2 * OS);
        check("b_first_valid", 32'(n_valid_b - vb0), 32'h1);
        check("b_first_data", 32'(data_b), 32'h2A);

        rx_b = 1'b0;
        tick(OS);
        for (int i = 0; i < 3; i++) begin
            rx_b = i[0];
            tick(OS);
        end
        rx_b = 1'b1;
        tick(OS / 2);
        rst_n = 1'b0;
        tick(2);
        check("b_rst_data", 32'(data_b), 32'h0);
        check("b_rst_valid", 32'(valid_b), 32'h0);
        check("b_rst_ferr", 32'(ferr_b), 32'h0);
        check("b_rst_perr", 32'(perr_b), 32'h0);
        check("b_rst_busy", 32'(busy_b), 32'h0);
        check("a_rst_data", 32'(data_a), 32'h0);
        rst_n = 1'b1;
        vb0 = n_valid_b;
        fb0 = n_ferr_b;
        tick(3 * 10 * OS);
        check("b_post_rst_no_valid", 32'(n_valid_b - vb0), 32'h0);
        check("b_post_rst_no_ferr", 32'(n_ferr_b - fb0), 32'h0);
        check("b_post_rst_busy", 32'(busy_b), 32'h0);

        send(1'b1, 9'h041, 7, 2, 1'b1, 1'b0, 1'b0);
        rx_b = 1'b1;
        tick(2 * OS);
        check("b_clean_valid", 32'(n_valid_b - vb0), 32'h1);
        check("b_clean_data", 32'(data_b), 32'h41);
        check("b_no_perr", 32'(n_perr_b), 32'h0);
        check("pulse_width", 32'(n_wide), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
